// File: rtl/gap_pkg.sv
// rtl/gap_pkg.sv - shared state type, constants and clog2 helper for global average pooling
package gap_pkg;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    CALC  = 2'd1,
    DRAIN = 2'd2
  } gap_state_e;

  // Reciprocal of 196 (14x14 frame) as 167 / 2^15
  localparam int GAP_RECIP_MULT_DEF  = 167;
  localparam int GAP_RECIP_SHIFT_DEF = 15;

  // ceil(log2(v)); returns 0 for v <= 1
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/gap_recip_div.sv
// rtl/gap_recip_div.sv - reciprocal-multiply divide with saturation; GAP_ROUND_EN selects round-half-up
module gap_recip_div
  import gap_pkg::*;
#(
  parameter int ACC_W       = 16,
  parameter int DATA_W      = 8,
  parameter int RECIP_MULT  = GAP_RECIP_MULT_DEF,
  parameter int RECIP_SHIFT = GAP_RECIP_SHIFT_DEF
) (
  input  logic [ACC_W-1:0]  acc_i,
  output logic [DATA_W-1:0] avg_o
);

  localparam int MULT_W = clog2(RECIP_MULT + 1);
  localparam int PROD_W = ACC_W + MULT_W;
  // One spare bit so the rounding bias can never wrap the product
  localparam int SUM_W  = PROD_W + 1;
  localparam logic [SUM_W-1:0]  MAX_WIDE = SUM_W'((1 << DATA_W) - 1);
  localparam logic [DATA_W-1:0] MAX_OUT  = DATA_W'((1 << DATA_W) - 1);

  logic [PROD_W-1:0] prod;
  logic [SUM_W-1:0]  biased;
  logic [SUM_W-1:0]  shifted;

  // Multiply by the reciprocal, optionally bias for rounding, shift down and clamp
  always_comb begin
    prod = PROD_W'(acc_i) * PROD_W'(RECIP_MULT);
`ifdef GAP_ROUND_EN
    biased = {1'b0, prod} + (SUM_W'(1) << (RECIP_SHIFT - 1));
`else
    biased = {1'b0, prod};
`endif
    shifted = biased >> RECIP_SHIFT;
    if (shifted > MAX_WIDE) avg_o = MAX_OUT;
    else                    avg_o = shifted[DATA_W-1:0];
  end

endmodule

// File: rtl/global_avg_pool_mc.sv
// rtl/global_avg_pool_mc.sv - multi-channel global average pooling with valid/ready (GAP_ROUND_EN: rounding)
module global_avg_pool_mc
  import gap_pkg::*;
#(
  parameter int IMG_W       = 14,
  parameter int IMG_H       = 14,
  parameter int NUM_CH      = 4,
  parameter int DATA_W      = 8,
  parameter int RECIP_MULT  = GAP_RECIP_MULT_DEF,
  parameter int RECIP_SHIFT = GAP_RECIP_SHIFT_DEF,
  localparam int TOTAL_PIX  = IMG_W * IMG_H,
  localparam int ACC_W      = DATA_W + clog2(TOTAL_PIX),
  localparam int CH_W       = (NUM_CH > 1) ? clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CH_W-1:0]   out_ch,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int PIX_W = (TOTAL_PIX > 1) ? clog2(TOTAL_PIX) : 1;
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(TOTAL_PIX - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);

  gap_state_e        state_q, state_d;
  logic [PIX_W-1:0]  pix_cnt_q, pix_cnt_d;
  logic [CH_W-1:0]   ch_cnt_q, ch_cnt_d;
  logic [ACC_W-1:0]  acc_q [NUM_CH];
  logic [ACC_W-1:0]  acc_d [NUM_CH];
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [CH_W-1:0]   out_ch_q, out_ch_d;
  logic              out_last_q, out_last_d;
  logic              out_valid_q, out_valid_d;

  logic [CH_W-1:0]   div_sel;
  logic [DATA_W-1:0] div_res;
  logic              accept;

  // Held low while reset is asserted so nothing upstream sees a spurious ready
  assign in_ready = rst_n && (state_q == ACCUM);
  assign accept   = in_valid && in_ready;

  // CALC always loads channel 0; DRAIN preloads the channel after the one on the bus
  assign div_sel = (state_q == DRAIN && out_ch_q != CH_LAST) ? out_ch_q + CH_W'(1) : '0;

  gap_recip_div #(
    .ACC_W      (ACC_W),
    .DATA_W     (DATA_W),
    .RECIP_MULT (RECIP_MULT),
    .RECIP_SHIFT(RECIP_SHIFT)
  ) u_div (
    .acc_i(acc_q[div_sel]),
    .avg_o(div_res)
  );

  // Next-state logic: accumulate, compute channel 0, then drain one channel per handshake
  always_comb begin
    state_d     = state_q;
    pix_cnt_d   = pix_cnt_q;
    ch_cnt_d    = ch_cnt_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;
    case (state_q)
      ACCUM: begin
        if (accept) begin
          acc_d[ch_cnt_q] = acc_q[ch_cnt_q] + ACC_W'(in_data);
          if (ch_cnt_q == CH_LAST) begin
            ch_cnt_d = '0;
            if (pix_cnt_q == PIX_LAST) begin
              pix_cnt_d = '0;
              state_d   = CALC;
            end else begin
              pix_cnt_d = pix_cnt_q + PIX_W'(1);
            end
          end else begin
            ch_cnt_d = ch_cnt_q + CH_W'(1);
          end
        end
      end
      CALC: begin
        out_data_d  = div_res;
        out_ch_d    = '0;
        out_last_d  = (NUM_CH == 1);
        out_valid_d = 1'b1;
        state_d     = DRAIN;
      end
      DRAIN: begin
        if (out_valid_q && out_ready) begin
          if (out_last_q) begin
            for (int c = 0; c < NUM_CH; c++) acc_d[c] = '0;
            out_valid_d = 1'b0;
            state_d     = ACCUM;
          end else begin
            out_data_d = div_res;
            out_ch_d   = div_sel;
            out_last_d = (div_sel == CH_LAST);
          end
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  // State and datapath registers; reset discards any partial frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      pix_cnt_q   <= '0;
      ch_cnt_q    <= '0;
      for (int c = 0; c < NUM_CH; c++) acc_q[c] <= '0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pix_cnt_q   <= pix_cnt_d;
      ch_cnt_q    <= ch_cnt_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_last  = out_last_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_global_avg_pool_mc.sv
// tb/tb_global_avg_pool_mc.sv - self-checking bench for global_avg_pool_mc against a reference average model
module tb_global_avg_pool_mc;

  localparam int NCH   = 4;
  localparam int TOT   = 196;
  localparam int NBEAT = NCH * TOT;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] out_data;
  logic [1:0] out_ch;
  logic       out_last;
  logic       out_valid;
  logic       out_ready = 1'b0;

  logic [7:0] in_data1 = '0;
  logic       in_valid1 = 1'b0;
  logic       in_ready1;
  logic [7:0] out_data1;
  logic       out_ch1;
  logic       out_last1;
  logic       out_valid1;
  logic       out_ready1 = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int beats [NBEAT];
  int expv  [NCH];

  global_avg_pool_mc #(
    .IMG_W(14), .IMG_H(14), .NUM_CH(NCH), .DATA_W(8), .RECIP_MULT(167), .RECIP_SHIFT(15)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_ch(out_ch), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  global_avg_pool_mc #(
    .IMG_W(14), .IMG_H(14), .NUM_CH(1), .DATA_W(8), .RECIP_MULT(167), .RECIP_SHIFT(15)
  ) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data1), .in_valid(in_valid1), .in_ready(in_ready1),
    .out_data(out_data1), .out_ch(out_ch1), .out_last(out_last1),
    .out_valid(out_valid1), .out_ready(out_ready1)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Mean of a channel: floor (or round-half-up) of sum * 167 / 2^15, clamped to 255
  function automatic int ref_avg(input longint sum);
    longint p;
    p = sum * 167;
`ifdef GAP_ROUND_EN
    p = p + 16384;
`endif
    p = p / 32768;
    return (p > 255) ? 255 : int'(p);
  endfunction

  task automatic model_frame();
    longint s [NCH];
    for (int c = 0; c < NCH; c++) s[c] = 0;
    for (int k = 0; k < NBEAT; k++) s[k % NCH] += beats[k];
    for (int c = 0; c < NCH; c++) expv[c] = ref_avg(s[c]);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer beats[0..n-1]; each returns one edge after its handshake
  task automatic push_frame(input int gap_pct, input int n);
    int budget;
    for (int k = 0; k < n; k++) begin
      if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        in_valid = 1'b0;
        step();
      end
      in_data  = 8'(beats[k]);
      in_valid = 1'b1;
      budget   = 0;
      while (!in_ready && budget < 200) begin
        step();
        budget++;
      end
      if (!in_ready) begin
        check("in_ready_timeout", in_ready, 1);
        in_valid = 1'b0;
        return;
      end
      step();
    end
  endtask

  // Called one edge after the last beat; mode 0 ready, 1 toggling, 2 random
  task automatic drain(input int mode, input bit junk);
    bit rdy;
    bit tog;
    int wait_c;
    tog       = 1'b0;
    in_valid  = junk;
    in_data   = 8'($urandom);
    out_ready = 1'b0;
    check("latency_early", out_valid, 0);
    step();
    check("latency_valid", out_valid, 1);
    for (int c = 0; c < NCH; c++) begin
      wait_c = 0;
      while (!out_valid && wait_c < 20) begin
        step();
        wait_c++;
      end
      check("out_valid", out_valid, 1);
      check("out_data", out_data, expv[c]);
      check("out_ch", out_ch, c);
      check("out_last", out_last, (c == NCH - 1));
      check("in_ready_drain", in_ready, 0);
      wait_c = 0;
      do begin
        case (mode)
          0:       rdy = 1'b1;
          1:       begin rdy = tog; tog = !tog; end
          default: rdy = 1'($urandom_range(1));
        endcase
        if (wait_c >= 30) rdy = 1'b1;
        out_ready = rdy;
        if (junk) in_data = 8'($urandom);
        step();
        if (!rdy) begin
          check("hold_valid", out_valid, 1);
          check("hold_data", out_data, expv[c]);
          check("hold_ch", out_ch, c);
          check("hold_last", out_last, (c == NCH - 1));
        end
        wait_c++;
      end while (!rdy);
      if (c < NCH - 1) check("no_bubble", out_valid, 1);
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("drain_done_valid", out_valid, 0);
    check("ready_after_drain", in_ready, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_out_ch"}, out_ch, 0);
    check({tag, "_out_last"}, out_last, 0);
  endtask

  task automatic fill_const(input int v);
    for (int k = 0; k < NBEAT; k++) beats[k] = v;
  endtask

  task automatic set_exp_all(input int v);
    for (int c = 0; c < NCH; c++) expv[c] = v;
  endtask

  initial begin
    int budget;
    // Reset state
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst");
    step();
    step();
    rst_n = 1'b1;
    step();
    check("rst_release_in_ready", in_ready, 1);
    check("rst_release_out_valid", out_valid, 0);

    // All 100, always ready
    fill_const(100);
`ifdef GAP_ROUND_EN
    set_exp_all(100);
`else
    set_exp_all(99);
`endif
    push_frame(0, NBEAT);
    drain(0, 1'b0);

    // Channel-dependent pattern
    for (int p = 0; p < TOT; p++) begin
      beats[p*NCH + 0] = p + 1;
      beats[p*NCH + 1] = 255;
      beats[p*NCH + 2] = 0;
      beats[p*NCH + 3] = 50;
    end
    expv[0] = 98;
    expv[2] = 0;
`ifdef GAP_ROUND_EN
    expv[1] = 255;
    expv[3] = 50;
`else
    expv[1] = 254;
    expv[3] = 49;
`endif
    push_frame(0, NBEAT);
    drain(0, 1'b0);

    // Toggling backpressure with in_valid pulses during drain
    fill_const(100);
    model_frame();
    push_frame(0, NBEAT);
    drain(1, 1'b1);

    // Back-to-back frames with in_valid held high throughout
    fill_const(10);
    model_frame();
    push_frame(0, NBEAT);
    drain(0, 1'b1);
    fill_const(20);
    model_frame();
    push_frame(0, NBEAT);
    drain(0, 1'b1);

    // Reset after 50 beats
    fill_const(200);
    push_frame(0, 50);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_midframe");
    step();
    rst_n = 1'b1;
    step();
    fill_const(10);
    model_frame();
    push_frame(0, NBEAT);
    drain(0, 1'b0);

    // Reset in the middle of draining
    fill_const(77);
    push_frame(0, NBEAT);
    in_valid = 1'b0;
    step();
    check("middrain_valid", out_valid, 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("middrain_ch1", out_ch, 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_middrain");
    step();
    rst_n = 1'b1;
    step();
    fill_const(10);
    model_frame();
    push_frame(0, NBEAT);
    drain(0, 1'b0);

    // Randomised frames, input gaps and output backpressure
    for (int f = 0; f < 4; f++) begin
      for (int k = 0; k < NBEAT; k++) begin
        case (f)
          0:       beats[k] = $urandom_range(20);
          1:       beats[k] = $urandom_range(200, 255);
          default: beats[k] = $urandom_range(255);
        endcase
      end
      model_frame();
      push_frame(30, NBEAT);
      drain(2, 1'(f & 1));
    end

    // Single-channel instance, all 255
    for (int k = 0; k < TOT; k++) begin
      in_data1  = 8'd255;
      in_valid1 = 1'b1;
      budget    = 0;
      while (!in_ready1 && budget < 50) begin
        step();
        budget++;
      end
      if (!in_ready1) begin
        check("nch1_in_ready_timeout", in_ready1, 1);
        break;
      end
      step();
    end
    in_valid1 = 1'b0;
    check("nch1_latency_early", out_valid1, 0);
    step();
    check("nch1_valid", out_valid1, 1);
`ifdef GAP_ROUND_EN
    check("nch1_data", out_data1, 255);
`else
    check("nch1_data", out_data1, 254);
`endif
    check("nch1_ch", out_ch1, 0);
    check("nch1_last", out_last1, 1);
    check("nch1_in_ready_drain", in_ready1, 0);
    out_ready1 = 1'b1;
    step();
    out_ready1 = 1'b0;
    check("nch1_done_valid", out_valid1, 0);
    check("nch1_ready_back", in_ready1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
